// File: rtl/frame_addr_gen.sv
// Raster-order source read addresses and interior-only destination write addresses for one frame.
// Optional build macro FRAME_ADDR_GEN_ERR_CHECK_EN adds rejection of tiny frames and an error pulse on surplus writes.
module frame_addr_gen #(
  parameter int unsigned PIXEL_BYTES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [15:0] length,
  input  logic [15:0] width,
  input  logic [31:0] source_addr,
  input  logic [31:0] dest_addr,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_addr,
  input  logic        wr_strobe,
  output logic [31:0] wr_addr,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [31:0] STEP     = 32'(PIXEL_BYTES);
  localparam logic [31:0] ROW_STEP = 32'(3 * PIXEL_BYTES);

  state_t      state_q, state_d;
  logic [15:0] len_q, wid_q;
  logic [15:0] rd_row_q, rd_col_q;
  logic [15:0] wr_row_q, wr_col_q;
  logic [31:0] rd_addr_q, wr_addr_q;
  logic        rd_done_q, wr_done_q;

  logic        small_frame;
  logic        start_ok;
  logic        rd_fire, wr_fire, rd_last;

  assign small_frame = (length < 16'd3) || (width < 16'd3);

`ifdef FRAME_ADDR_GEN_ERR_CHECK_EN
  logic err_q;
  assign start_ok = start && !small_frame;
`else
  assign start_ok = start;
`endif

  assign rd_fire = rd_valid && rd_ready;
  assign wr_fire = (state_q == ST_RUN) && wr_strobe && !wr_done_q;
  assign rd_last = (rd_col_q == wid_q - 16'd1) && (rd_row_q == len_q - 16'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (rd_done_q && wr_done_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    rd_valid = (state_q == ST_RUN) && !rd_done_q;
  end

  // NOTE: every datapath register, including latched config, is cleared by reset so a mid-frame abort leaves no stale state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      len_q     <= '0;
      wid_q     <= '0;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else if (state_q == ST_IDLE && start_ok) begin
      len_q     <= length;
      wid_q     <= width;
      rd_row_q  <= '0;
      rd_col_q  <= '0;
      wr_row_q  <= 16'd1;
      wr_col_q  <= 16'd1;
      rd_addr_q <= source_addr;
      wr_addr_q <= dest_addr + ({16'd0, width} + 32'd1) * STEP;
      rd_done_q <= (length == 16'd0) || (width == 16'd0);
      wr_done_q <= small_frame;
    end else begin
      if (rd_fire) begin
        rd_addr_q <= rd_addr_q + STEP;
        if (rd_last) begin
          rd_done_q <= 1'b1;
        end else if (rd_col_q == wid_q - 16'd1) begin
          rd_col_q <= '0;
          rd_row_q <= rd_row_q + 16'd1;
        end else begin
          rd_col_q <= rd_col_q + 16'd1;
        end
      end
      // Last interior column skips the right border and next row's left border.
      if (wr_fire) begin
        if (wr_col_q == wid_q - 16'd2) begin
          wr_addr_q <= wr_addr_q + ROW_STEP;
          wr_col_q  <= 16'd1;
          if (wr_row_q == len_q - 16'd2) wr_done_q <= 1'b1;
          else                           wr_row_q  <= wr_row_q + 16'd1;
        end else begin
          wr_addr_q <= wr_addr_q + STEP;
          wr_col_q  <= wr_col_q + 16'd1;
        end
      end
    end
  end

`ifdef FRAME_ADDR_GEN_ERR_CHECK_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err_q <= 1'b0;
    else        err_q <= ((state_q == ST_IDLE) && start && small_frame) ||
                         ((state_q == ST_RUN) && wr_strobe && wr_done_q);
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_frame_addr_gen.sv
// Randomized and directed checks of frame_addr_gen against a list-based model of the frame's address sequences.
module tb_frame_addr_gen;

  localparam int PB = 1;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [15:0] length, width;
  logic [31:0] source_addr, dest_addr;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_addr, wr_addr;
  logic        wr_strobe;
  logic        busy, done, error;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  frame_addr_gen #(.PIXEL_BYTES(PB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .length(length), .width(width),
    .source_addr(source_addr), .dest_addr(dest_addr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_addr(rd_addr), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_rdv"},   32'(rd_valid), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(error), 0);
    check({tag, "_rdaddr"}, rd_addr, 0);
    check({tag, "_wraddr"}, wr_addr, 0);
  endtask

  // mode: 0 = rd_ready always high, 1 = toggling, 2 = random. noisy scrambles inputs and pulses start mid-frame.
  task automatic run_frame(input int L, input int W, input logic [31:0] src, input logic [31:0] dst,
                           input int mode, input bit noisy);
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    logic [31:0] wr_end, held;
    int ri = 0, wi = 0, nv = 0, dn = 0, en = 0, extra = 0, nw, exp_err;
    bit stall = 0, fin = 0;

    for (int r = 0; r < L; r++)
      for (int c = 0; c < W; c++)
        exp_rd.push_back(src + 32'((r * W + c) * PB));
    for (int r = 1; r <= L - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        exp_wr.push_back(dst + 32'((r * W + c) * PB));
    nw = exp_wr.size();
    wr_end = (nw > 0) ? dst + 32'(((L - 1) * W + 1) * PB) : dst + 32'((W + 1) * PB);

    @(negedge HCLK);
    start = 1'b1; length = 16'(L); width = 16'(W); source_addr = src; dest_addr = dst;
    rd_ready = (mode == 1) ? 1'b0 : 1'b1;
    wr_strobe = 1'($urandom_range(0, 1));

`ifdef FRAME_ADDR_GEN_ERR_CHECK_EN
    if (L < 3 || W < 3) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge HCLK);
        start = 1'b0;
        if (error) en++;
        if (busy || done || rd_valid) dn++;
      end
      check("err_reject", en, 1);
      check("err_quiet", dn, 0);
      return;
    end
`endif

    for (int cyc = 0; cyc < 4 * L * W + 40 && !fin; cyc++) begin
      @(negedge HCLK);
      if (cyc == 0) check("busy_start", 32'(busy), 1);
      if (stall) begin
        check("rd_hold_v", 32'(rd_valid), 1);
        check("rd_hold_a", rd_addr, held);
      end
      if (error) en++;
      if (rd_valid) nv++;
      if (done) begin
        dn++;
        fin = 1;
        check("rd_at_done", ri, L * W);
        check("wr_at_done", wi, nw);
        check("busy_in_done", 32'(busy), 0);
      end

      start = 1'b0;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        length = 16'($urandom_range(0, 9));
        width = 16'($urandom_range(0, 9));
        source_addr = $urandom;
        dest_addr = $urandom;
      end
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      wr_strobe = busy ? 1'($urandom_range(0, 1)) : 1'b0;

      if (rd_valid && rd_ready) begin
        if (ri < exp_rd.size()) check("rd_addr", rd_addr, exp_rd[ri]);
        else                    check("rd_extra", 32'(rd_valid), 0);
        ri++;
      end
      stall = rd_valid && !rd_ready;
      held = rd_addr;
      if (wr_strobe) begin
        if (wi < nw) begin
          check("wr_addr", wr_addr, exp_wr[wi]);
          wi++;
        end else begin
          extra++;
          check("wr_after", wr_addr, wr_end);
        end
      end
    end
    if (!fin) check("timeout", 32'(done), 1);

    @(negedge HCLK);
    check("done_once", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("rd_count", ri, L * W);
    check("wr_count", wi, nw);
    check("done_pulses", dn, 1);
    if (mode == 0) check("rd_cycles", nv, L * W);
`ifdef FRAME_ADDR_GEN_ERR_CHECK_EN
    exp_err = extra;
`else
    exp_err = 0;
`endif
    check("err_pulses", en, exp_err);
    start = 1'b0;
    wr_strobe = 1'b0;
  endtask

  task automatic reset_mid_frame();
    @(negedge HCLK);
    start = 1'b1; length = 16'd4; width = 16'd5;
    source_addr = 32'h3000; dest_addr = 32'h4000; rd_ready = 1'b1; wr_strobe = 1'b0;
    @(negedge HCLK);
    start = 1'b0;
    repeat (7) @(negedge HCLK);
    check("pre_reset_addr", rd_addr, 32'h3007);
    HRESET = 1'b1;
    #1;
    check_quiet("reset_async");
    @(negedge HCLK);
    check_quiet("reset_held");
    HRESET = 1'b0;
    wr_strobe = 1'b1;
    repeat (3) @(negedge HCLK);
    check_quiet("post_reset");
    wr_strobe = 1'b0;
    run_frame(3, 3, 32'h5000, 32'h6000, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; start = 1'b0; length = '0; width = '0;
    source_addr = '0; dest_addr = '0; rd_ready = 1'b0; wr_strobe = 1'b0;
    #1;
    check_quiet("reset");
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    run_frame(4, 5, 32'h1000, 32'h2000, 0, 0);
    run_frame(4, 5, 32'h1000, 32'h2000, 1, 0);
    run_frame(2, 2, 32'hFFFF_FFFE, 32'h7000, 0, 0);
    run_frame(5, 4, 32'h8000, 32'hFFFF_FFF0, 2, 1);
    run_frame(0, 5, 32'h100, 32'h200, 0, 0);
    run_frame(3, 0, 32'h100, 32'h200, 0, 0);
    run_frame(1, 6, 32'h300, 32'h400, 2, 0);
    reset_mid_frame();
    for (int i = 0; i < 12; i++)
      run_frame($urandom_range(0, 6), $urandom_range(0, 7), $urandom, $urandom,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_addr_gen.md
FRAME_ADDR_GEN -- requirements
Module: frame_addr_gen

Interface
REQ-001 Parameter PIXEL_BYTES, default 1: byte step between adjacent pixels.
REQ-002 HCLK  input  1  sole clock; all state on rising edge.
REQ-003 HRESET  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a frame.
REQ-005 length  input  16  frame row count, from the AHB decoder.
REQ-006 width  input  16  frame column count, from the AHB decoder.
REQ-007 source_addr  input  32  source frame base byte address.
REQ-008 dest_addr  input  32  destination frame base byte address.
REQ-009 rd_valid  output  1  rd_addr holds a valid source pixel address.
REQ-010 rd_ready  input  1  consumer accepts rd_addr when rd_valid && rd_ready.
REQ-011 rd_addr  output  32  current source pixel address.
REQ-012 wr_strobe  input  1  processing core emits one result pixel this cycle.
REQ-013 wr_addr  output  32  destination address for the next result pixel.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 error  output  1  one-cycle fault pulse (ERR_CHECK_EN builds only; tied 0 otherwise).

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when reads and writes both complete; DONE->IDLE unconditionally next cycle.
REQ-018 On start in IDLE: latch length, width, source_addr, dest_addr; later input changes have no effect until the next start.
REQ-019 start while in RUN or DONE is ignored.
REQ-020 Read channel: rd_valid high in RUN until length*width accepted handshakes occur; addresses are raster order, source_addr + (r*width + c)*PIXEL_BYTES.
REQ-021 rd_addr and rd_valid are stable while rd_valid && !rd_ready; rd_addr advances by PIXEL_BYTES the cycle after each handshake.
REQ-022 Write channel covers interior pixels only: rows 1..length-2, cols 1..width-2; count (length-2)*(width-2).
REQ-023 First wr_addr = dest_addr + (width+1)*PIXEL_BYTES; each wr_strobe advances PIXEL_BYTES, except after col width-2, where it advances 3*PIXEL_BYTES.
REQ-024 Address adds wrap modulo 2^32; row/column counters are 16-bit.
REQ-025 wr_strobe outside RUN, or after all writes are done, has no effect on wr_addr.
REQ-026 Simultaneous read handshake and wr_strobe are both processed in the same cycle.
REQ-027 length<3 or width<3 (no ERR_CHECK_EN): write count is 0; done follows the last read handshake.
REQ-028 length==0 or width==0 (no ERR_CHECK_EN): RUN lasts one cycle with rd_valid low; then DONE.
REQ-029 done asserts in DONE only; busy is 0 in IDLE and DONE.

Reset
REQ-030 HRESET asserted (including mid-frame): state IDLE; rd_valid, busy, done, error = 0; rd_addr, wr_addr, counters, latched config = 0.
REQ-031 After HRESET deasserts, no activity until the next start.

Configuration
REQ-032 Macro FRAME_ADDR_GEN_ERR_CHECK_EN defined: start with length<3 or width<3 pulses error one cycle and stays IDLE, with no reads and no done.
REQ-033 Same macro defined: wr_strobe in RUN after all writes are done pulses error; the frame continues.
REQ-034 Macro undefined: error tied 0; REQ-027/028 apply.

Verification
REQ-035 PIXEL_BYTES=1, length=4, width=5, source_addr=0x1000, rd_ready=1 -> rd_addr 0x1000..0x1013 over 20 consecutive cycles, then rd_valid=0.
REQ-036 Same frame, dest_addr=0x2000, 6 wr_strobes -> wr_addr 0x2006,0x2007,0x2008,0x200B,0x200C,0x200D; done pulses once after the last read and write.
REQ-037 rd_ready toggled 0/1 each cycle -> rd_addr held while stalled; exactly 20 handshakes with no skipped or repeated address.
REQ-038 source_addr=0xFFFFFFFE, 2x2 frame -> rd_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; no writes; done pulses (error build: error pulse, no reads).
REQ-039 HRESET asserted after 7 reads -> all outputs 0 next edge; new start with length=3, width=3 -> rd_addr restarts at source_addr, one write at dest_addr+4.
REQ-040 start during RUN with different length -> ignored; original frame completes unchanged.
